// File: rtl/mem_boot_loader_pkg.sv
// Shared types and header field layout for the boot loader.
// Header layout: count-1 in the low ADDR_W bits, then base, then target; MSB flags the last section.
package mem_boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    LOAD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int HDR_CNT_LSB = 0;

  function automatic int tgt_width(input int num_tgt);
    return (num_tgt > 1) ? $clog2(num_tgt) : 1;
  endfunction

  function automatic int hdr_base_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int hdr_tgt_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

endpackage

// File: rtl/mem_boot_loader_if.sv
// Word stream in, memory write ports and CPU status out.
// master = stream source / status observer, slave = the loader.
interface mem_boot_loader_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_TGT = 2
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [NUM_TGT-1:0] wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/mem_boot_loader_hdr_decode.sv
// Splits a section header word into its fields; purely combinational, no flow control.
module boot_hdr_decode
  import mem_boot_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_TGT = 2
) (
  input  logic [DATA_W-1:0]              hdr,
  output logic [ADDR_W-1:0]              cnt_m1,
  output logic [ADDR_W-1:0]              base,
  output logic [tgt_width(NUM_TGT)-1:0]  tgt,
  output logic                           last,
  output logic                           tgt_ok
);
  localparam int TGT_W = tgt_width(NUM_TGT);

  assign cnt_m1 = hdr[HDR_CNT_LSB +: ADDR_W];
  assign base   = hdr[hdr_base_lsb(ADDR_W) +: ADDR_W];
  assign tgt    = hdr[hdr_tgt_lsb(ADDR_W) +: TGT_W];
  assign last   = hdr[DATA_W-1];
  assign tgt_ok = (32'(tgt) < NUM_TGT);

  // Bits between the target field and the last flag are reserved.
  logic hdr_unused;
  assign hdr_unused = ^hdr;
endmodule

// File: rtl/mem_boot_loader.sv
// Streams header+data sections into memory write ports, holding the CPU until the image is in.
// Writes are registered (one cycle after the transfer); the source may stall in_valid indefinitely.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int NUM_TGT = 2
) (
  input logic            clk,
  input logic            rst_n,
  mem_boot_loader_if.slave bus
);
  localparam int TGT_W = tgt_width(NUM_TGT);
  localparam logic [ADDR_W:0] REMAIN_ONE = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W:0]     remain;
  logic [ADDR_W-1:0]   addr;
  logic [TGT_W-1:0]    tgt_q;
  logic                last_q;
  logic                tgt_ok_q;

  logic [NUM_TGT-1:0]  wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                busy_q, done_q, err_q, cpu_hold_q;

  logic [ADDR_W-1:0]   h_cnt_m1, h_base;
  logic [TGT_W-1:0]    h_tgt;
  logic                h_last, h_tgt_ok;
  logic                xfer;
  logic [NUM_TGT-1:0]  tgt_onehot;

  boot_hdr_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_TGT(NUM_TGT)
  ) u_hdr (
    .hdr   (bus.in_data),
    .cnt_m1(h_cnt_m1),
    .base  (h_base),
    .tgt   (h_tgt),
    .last  (h_last),
    .tgt_ok(h_tgt_ok)
  );

  assign bus.in_ready = (state == HEADER) || (state == LOAD);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign tgt_onehot   = NUM_TGT'(1) << tgt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      remain     <= '0;
      addr       <= '0;
      tgt_q      <= '0;
      last_q     <= 1'b0;
      tgt_ok_q   <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      wr_en_q <= '0;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= HEADER;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        HEADER: begin
          if (xfer) begin
            remain   <= {1'b0, h_cnt_m1} + REMAIN_ONE;
            addr     <= h_base;
            tgt_q    <= h_tgt;
            last_q   <= h_last;
            tgt_ok_q <= h_tgt_ok;
            if (!h_tgt_ok) err_q <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            // A bad-target section is still consumed, just never strobed.
            if (tgt_ok_q) wr_en_q <= tgt_onehot;
            wr_addr_q <= addr;
            wr_data_q <= bus.in_data;
            addr      <= addr + ADDR_W'(1);
            remain    <= remain - REMAIN_ONE;
            if (remain == REMAIN_ONE) state <= last_q ? DONE : HEADER;
          end
        end
        DONE: begin
          state      <= IDLE;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.cpu_hold = cpu_hold_q;
endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: cycle table for the basic image plus multi-section sequences.
// Three targets give a 2-bit target field, so target 3 is encodable and out of range.
module tb_mem_boot_loader;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_boot_loader_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_TGT(NT)) bus ();

  mem_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_TGT(NT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [2:0]  en;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        start;
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic [2:0]  en;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic        busy;
    logic        done;
    logic        hold;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int overlap = 0;
  int orphan = 0;
  logic xfer_prev = 1'b0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [31:0] img[$];
  vec_t tbl[8];

  // Write/done observer; a strobe must follow a transfer on the previous edge.
  always @(negedge clk) begin
    if (bus.wr_en != 3'b000) begin
      got_q.push_back('{bus.wr_en, bus.wr_addr, bus.wr_data});
      if (!xfer_prev) orphan++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (bus.wr_en != 3'b000) overlap++;
    end
    xfer_prev = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] hdr(input logic last, input logic [1:0] tgt,
                                      input logic [7:0] base, input logic [7:0] cm1);
    return {last, 13'b0, tgt, base, cm1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, " wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, " wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, " wr_data"}, bus.wr_data, 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " err"}, 32'(bus.err), 0);
    chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input bit gaps);
    int n;
    logic ok;
    if (gaps) repeat ($urandom_range(0, 1)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    do begin
      ok = bus.in_ready;
      tick();
      n++;
    end while (!ok && n < 20);
    bus.in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL ready-timeout word %0h in_ready %0b expected 1", d, ok);
    end
  endtask

  task automatic run_image(input string nm, input bit gaps);
    int d0;
    int n;
    d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    foreach (img[i]) put(img[i], gaps);
    n = 0;
    while (done_cnt == d0 && n < 30) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({nm, " done pulses"}, 32'(done_cnt - d0), 1);
    chk({nm, " cpu_hold after"}, 32'(bus.cpu_hold), 0);
    chk({nm, " busy after"}, 32'(bus.busy), 0);
  endtask

  task automatic ew(input logic [2:0] en, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{en, a, d});
  endtask

  task automatic check_writes(input string nm, input int from);
    chk({nm, " write count"}, 32'(got_q.size() - from), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && from + i < got_q.size(); i++) begin
      chk($sformatf("%s wr%0d en", nm, i), 32'(got_q[from+i].en), 32'(exp_q[i].en));
      chk($sformatf("%s wr%0d addr", nm, i), 32'(got_q[from+i].addr), 32'(exp_q[i].addr));
      chk($sformatf("%s wr%0d data", nm, i), got_q[from+i].data, exp_q[i].data);
    end
    exp_q.delete();
  endtask

  initial begin
    int base;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    tbl[0] = '{1'b1, 1'b0, 32'h0,            1'b1, 3'b000, 8'h0, 32'h0,         1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, hdr(1, 0, 0, 3), 1'b1, 3'b000, 8'h0, 32'h0,         1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 32'hA000_00A0,    1'b1, 3'b001, 8'h0, 32'hA000_00A0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'hA000_00A1,    1'b1, 3'b001, 8'h1, 32'hA000_00A1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'hA000_00A2,    1'b1, 3'b001, 8'h2, 32'hA000_00A2, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'hA000_00A3,    1'b0, 3'b001, 8'h3, 32'hA000_00A3, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h0,            1'b0, 3'b000, 8'h0, 32'h0,         1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,            1'b0, 3'b000, 8'h0, 32'h0,         1'b0, 1'b0, 1'b0};

    repeat (2) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("idle cpu_hold", 32'(bus.cpu_hold), 1);

    // Basic image, cycle by cycle; start in row 3 lands in LOAD and must be ignored.
    for (int i = 0; i < 8; i++) begin
      bus.start    = tbl[i].start;
      bus.in_valid = tbl[i].vld;
      bus.in_data  = tbl[i].dat;
      tick();
      chk($sformatf("t1[%0d] in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("t1[%0d] wr_en", i), 32'(bus.wr_en), 32'(tbl[i].en));
      if (tbl[i].en != 3'b000) begin
        chk($sformatf("t1[%0d] wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].addr));
        chk($sformatf("t1[%0d] wr_data", i), bus.wr_data, tbl[i].wdat);
      end
      chk($sformatf("t1[%0d] busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("t1[%0d] done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("t1[%0d] cpu_hold", i), 32'(bus.cpu_hold), 32'(tbl[i].hold));
      chk($sformatf("t1[%0d] err", i), 32'(bus.err), 0);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;

    // Two sections to different targets.
    base = got_q.size();
    img = {hdr(0, 0, 8'h10, 1), 32'hB000_0000, 32'hB000_0001,
           hdr(1, 1, 8'h00, 2), 32'hC000_0000, 32'hC000_0001, 32'hC000_0002};
    run_image("t2", 1'b0);
    ew(3'b001, 8'h10, 32'hB000_0000);
    ew(3'b001, 8'h11, 32'hB000_0001);
    ew(3'b010, 8'h00, 32'hC000_0000);
    ew(3'b010, 8'h01, 32'hC000_0001);
    ew(3'b010, 8'h02, 32'hC000_0002);
    check_writes("t2", base);

    // Address wrap-around.
    base = got_q.size();
    img = {hdr(1, 0, 8'hFE, 3), 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    run_image("t3", 1'b0);
    ew(3'b001, 8'hFE, 32'hD000_0000);
    ew(3'b001, 8'hFF, 32'hD000_0001);
    ew(3'b001, 8'h00, 32'hD000_0002);
    ew(3'b001, 8'h01, 32'hD000_0003);
    check_writes("t3", base);
    chk("t3 err clear", 32'(bus.err), 0);

    // Out-of-range target is drained silently and latches err.
    base = got_q.size();
    img = {hdr(0, 3, 8'h20, 1), 32'hE000_0000, 32'hE000_0001,
           hdr(1, 1, 8'h05, 0), 32'hE000_0002};
    run_image("t4", 1'b0);
    ew(3'b010, 8'h05, 32'hE000_0002);
    check_writes("t4", base);
    chk("t4 err set", 32'(bus.err), 1);
    repeat (4) tick();
    chk("t4 err sticky", 32'(bus.err), 1);

    // Basic image with random source stalls.
    base = got_q.size();
    img = {hdr(1, 0, 0, 3), 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3};
    run_image("t5", 1'b1);
    for (int i = 0; i < 4; i++) ew(3'b001, 8'(i), 32'hA000_00A0 + 32'(i));
    check_writes("t5", base);

    // Reset in the middle of a section.
    base = got_q.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    put(hdr(1, 0, 0, 3), 1'b0);
    put(32'hA000_00A0, 1'b0);
    put(32'hA000_00A1, 1'b0);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA000_00A2;
    tick();
    chk_reset("t6 reset");
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (4) tick();
    ew(3'b001, 8'h00, 32'hA000_00A0);
    ew(3'b001, 8'h01, 32'hA000_00A1);
    check_writes("t6 aborted", base);

    base = got_q.size();
    img = {hdr(1, 0, 0, 3), 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3};
    run_image("t6 rerun", 1'b0);
    for (int i = 0; i < 4; i++) ew(3'b001, 8'(i), 32'hA000_00A0 + 32'(i));
    check_writes("t6 rerun", base);

    chk("done/write overlap", 32'(overlap), 0);
    chk("write without transfer", 32'(orphan), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
